mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit that produces the HI and LO values consumed by the register-file write-data selector and by the mfhi/mflo datapath. It sits beside the ALU in the multicycle datapath. The control FSM starts an operation with a one-cycle start pulse, then waits for the `Done` pulse before writing HI/LO back through the write-data mux.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// Optional macro MULTDIV_DIV0_TRAP_EN: divide by zero finishes immediately with a DivZero pulse.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MultStart,
  input  logic        DivStart,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Done,
  output logic        DivZero,
  output logic        Busy
);

`ifdef MULTDIV_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] a_reg;
  logic [31:0] b_mag;
  logic [32:0] acc_hi;   // Booth P_hi (one guard bit) or division remainder
  logic [31:0] acc_lo;   // Booth P_lo or dividend/quotient shift register
  logic        q_m1;
  logic        a_neg;
  logic        q_neg;
  logic        b_zero;

  logic [32:0] a_ext;
  logic [32:0] booth_sum;
  logic [65:0] mult_shift;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [32:0] div_rem_nx;
  logic [31:0] div_quo_nx;
  logic [31:0] quo_res;
  logic [31:0] rem_res;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;

  // The guard bit keeps +/- 0x80000000 partial sums from wrapping.
  assign a_ext = {a_reg[31], a_reg};

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + a_ext;
      2'b10:   booth_sum = acc_hi - a_ext;
      default: booth_sum = acc_hi;
    endcase
  end

  assign mult_shift = {booth_sum[32], booth_sum, acc_lo};

  assign div_shift  = {acc_hi[31:0], acc_lo[31]};
  assign div_diff   = div_shift - {1'b0, b_mag};
  assign div_ge     = ~div_diff[32];
  assign div_rem_nx = div_ge ? div_diff : div_shift;
  assign div_quo_nx = {acc_lo[30:0], div_ge};
  assign quo_res    = q_neg ? -div_quo_nx : div_quo_nx;
  assign rem_res    = a_neg ? -div_rem_nx[31:0] : div_rem_nx[31:0];

  assign a_mag_in = A[31] ? -A : A;
  assign b_mag_in = B[31] ? -B : B;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_mag   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      q_m1    <= 1'b0;
      a_neg   <= 1'b0;
      q_neg   <= 1'b0;
      b_zero  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MultStart) begin
            a_reg  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            q_m1   <= 1'b0;
            cnt    <= 6'd32;
            Busy   <= 1'b1;
            state  <= MULT;
          end else if (DivStart) begin
            if (TRAP_EN && (B == 32'd0)) begin
              Done    <= 1'b1;
              DivZero <= 1'b1;
              state   <= DONE;
            end else begin
              a_reg  <= A;
              acc_hi <= '0;
              acc_lo <= a_mag_in;
              b_mag  <= b_mag_in;
              a_neg  <= A[31];
              q_neg  <= A[31] ^ B[31];
              b_zero <= (B == 32'd0);
              cnt    <= 6'd32;
              Busy   <= 1'b1;
              state  <= DIV;
            end
          end
        end
        MULT: begin
          acc_hi <= mult_shift[65:33];
          acc_lo <= mult_shift[32:1];
          q_m1   <= mult_shift[0];
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            HI    <= mult_shift[64:33];
            LO    <= mult_shift[32:1];
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= DONE;
          end
        end
        DIV: begin
          acc_hi <= div_rem_nx;
          acc_lo <= div_quo_nx;
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            // Untrapped divide by zero returns a fixed pattern instead of the raw shift result.
            HI    <= b_zero ? a_reg : rem_res;
            LO    <= b_zero ? 32'hFFFF_FFFF : quo_res;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          DivZero <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus directed multi-cycle sequences,
// results checked through a scoreboard queue popped on each Done pulse.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Done;
  logic        DivZero;
  logic        Busy;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .MultStart (MultStart),
    .DivStart  (DivStart),
    .HI        (HI),
    .LO        (LO),
    .Done      (Done),
    .DivZero   (DivZero),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ms;
    logic        ds;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int dz_cnt = 0;
  int exp_done = 0;

  always @(negedge clk) begin
    if (Done)    done_cnt++;
    if (DivZero) dz_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives a start, waits for Done, checks latency, Busy and results.
  task automatic run_op(input string name, input logic ms, input logic ds,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int elat, input int poke_at, input bit poke_done);
    exp_t e;
    exp_t got;
    int   cyc;
    int   busy;
    bit   seen;
    cyc  = 0;
    busy = 0;
    seen = 1'b0;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    sb_q.push_back(e);
    exp_done++;
    A = a;
    B = b;
    MultStart = ms;
    DivStart  = ds;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      MultStart = 1'b0;
      DivStart  = (cyc == poke_at);
      if (Busy) busy++;
      if (Done) seen = 1'b1;
    end
    DivStart = 1'b0;
    got = sb_q.pop_front();
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: no Done within %0d cycles", name, cyc);
    end else begin
      check({name, " latency"}, cyc, elat);
      check({name, " busy"}, busy, elat - 1);
      check({name, " HI"}, HI, got.hi);
      check({name, " LO"}, LO, got.lo);
      check({name, " DivZero"}, {31'd0, DivZero}, {31'd0, got.dz});
    end
    if (poke_done) DivStart = 1'b1;
    @(negedge clk);
    DivStart = 1'b0;
    check({name, " Done width"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    longint pa;
    longint pb;
    longint prod;
    longint quo;
    longint rem;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] dz_hi;
    logic [31:0] dz_lo;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    int          done_snap;

    reset = 1'b1;
    A = '0;
    B = '0;
    MultStart = 1'b0;
    DivStart  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset Done", {31'd0, Done}, 32'd0);
    check("reset DivZero", {31'd0, DivZero}, 32'd0);
    check("reset Busy", {31'd0, Busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2,         32'd14};
    vecs[5] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{1'b1, 1'b1, 32'd6,          32'd3,          32'd0,         32'd18};
    for (int i = 7; i < 13; i++) begin
      ra = $urandom;
      rb = $urandom;
      pa = longint'($signed(ra));
      if (i % 2 == 1) begin
        pb   = longint'($signed(rb));
        prod = pa * pb;
        vecs[i] = '{1'b1, 1'b0, ra, rb, prod[63:32], prod[31:0]};
      end else begin
        if (rb == 32'd0) rb = 32'd13;
        pb  = longint'($signed(rb));
        quo = pa / pb;
        rem = pa % pb;
        vecs[i] = '{1'b0, 1'b1, ra, rb, rem[31:0], quo[31:0]};
      end
    end

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].ms, vecs[i].ds, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, 1'b0, 33, 0, 1'b0);

    // Divide by zero with HI/LO preloaded by a multiply.
    run_op("preload", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           1'b0, 33, 0, 1'b0);
`ifdef MULTDIV_DIV0_TRAP_EN
    dz_hi = 32'hFFFF_FFFF;
    dz_lo = 32'hFFFF_FFEB;
    run_op("div0", 1'b0, 1'b1, 32'd100, 32'd0, dz_hi, dz_lo, 1'b1, 1, 0, 1'b0);
`else
    dz_hi = 32'd100;
    dz_lo = 32'hFFFF_FFFF;
    run_op("div0", 1'b0, 1'b1, 32'd100, 32'd0, dz_hi, dz_lo, 1'b0, 33, 0, 1'b0);
`endif

    // Reset at iteration 10 of a multiply aborts it without a Done.
    done_snap = done_cnt;
    A = 32'h1234;
    B = 32'h55;
    MultStart = 1'b1;
    @(negedge clk);
    MultStart = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    check("abort Busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort no Done", done_cnt, done_snap);
    run_op("after reset", 1'b1, 1'b0, 32'd5, 32'd9, 32'd0, 32'd45, 1'b0, 33, 0, 1'b0);

    // DivStart mid-operation and during DONE must be ignored.
    done_snap = done_cnt;
    run_op("ignored starts", 1'b1, 1'b0, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 33, 5, 1'b1);
    hold_hi = 32'd0;
    hold_lo = 32'd143;
    repeat (40) @(negedge clk);
    check("single Done", done_cnt - done_snap, 32'd1);
    check("idle Busy", {31'd0, Busy}, 32'd0);
    check("hold HI", HI, hold_hi);
    check("hold LO", LO, hold_lo);

    check("total Done", done_cnt, exp_done);
`ifdef MULTDIV_DIV0_TRAP_EN
    check("DivZero pulses", dz_cnt, 32'd1);
`else
    check("DivZero pulses", dz_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
